// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the word-addressed data-memory interface. Takes one
// load/store request at a time from the MEM stage, performs byte/halfword
// loads with sign or zero extension, and implements sub-word stores as a
// read-modify-write of the containing word. Misaligned and out-of-range
// requests complete immediately with a fault flag and touch no memory.
// Byte order inside a word is big-endian (byte offset 0 = bits [31:24]).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request strobe, sampled only in IDLE
//   op           0=LB 1=LH 2=LW 3=LBU 4=LHU 5=SB 6=SH 7=SW
//   addr         byte address
//   store_data   store source, byte/half taken from the LSBs
//   busy         high while a memory access is in flight (READ/WRITE)
//   done         one-cycle completion pulse
//   load_result  extended load data, held until the next load completes
//   misaligned   alignment fault, valid with done
//   range_fault  address >= ADDR_LIMIT, valid with done
//   mem_read     memory read strobe
//   mem_write    memory write strobe
//   mem_addr     word-aligned memory address
//   mem_wdata    memory write data
//   mem_rdata    memory read data, combinational from mem_addr
// ---------------------------------------------------------------------------
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; request and fault decode latched on accept
// S_READ  | mem_read for one cycle; load extracted or sub-word merged
// S_WRITE | mem_write for one cycle with merged word or full store word
// S_DONE  | done pulse with fault flags; start ignored
//
module load_store_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        misaligned,
    output logic        range_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] merge_q;
    logic [31:0] load_result_q;
    logic        mis_q;
    logic        rf_q;

    logic        req_mis;
    logic        req_rf;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_half(input logic [2:0] o);
        is_half = (o == OP_LH) || (o == OP_LHU) || (o == OP_SH);
    endfunction

    function automatic logic is_word(input logic [2:0] o);
        is_word = (o == OP_LW) || (o == OP_SW);
    endfunction

    function automatic logic is_store(input logic [2:0] o);
        is_store = (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  o,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        case (off)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (o)
            OP_LB:   extend_load = {{24{b[7]}}, b};
            OP_LBU:  extend_load = {24'h000000, b};
            OP_LH:   extend_load = {{16{h[15]}}, h};
            OP_LHU:  extend_load = {16'h0000, h};
            default: extend_load = word;
        endcase
    endfunction

    // Insert the byte/half of the store source into the word just read.
    function automatic logic [31:0] merge_word(input logic [31:0] word,
                                               input logic [2:0]  o,
                                               input logic [1:0]  off,
                                               input logic [31:0] data);
        merge_word = word;
        if (o == OP_SB) begin
            case (off)
                2'd0: merge_word[31:24] = data[7:0];
                2'd1: merge_word[23:16] = data[7:0];
                2'd2: merge_word[15:8]  = data[7:0];
                2'd3: merge_word[7:0]   = data[7:0];
                default: merge_word = word;
            endcase
        end else begin
            if (off[1]) begin
                merge_word[15:0] = data[15:0];
            end else begin
                merge_word[31:16] = data[15:0];
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Fault decode on the incoming request; misalignment wins over range.
    // ------------------------------------------------------------------
    always_comb begin
        req_mis = (is_half(op) && addr[0]) ||
                  (is_word(op) && (addr[1:0] != 2'b00));
        req_rf  = (addr >= ADDR_LIMIT);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_mis || req_rf) begin
                        state_d = S_DONE;
                    end else if (op == OP_SW) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = is_store(op_q) ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state, so strobes fall with rst_n directly.
    // ------------------------------------------------------------------
    always_comb begin
        mem_read    = (state_q == S_READ);
        mem_write   = (state_q == S_WRITE);
        busy        = (state_q == S_READ) || (state_q == S_WRITE);
        done        = (state_q == S_DONE);
        misaligned  = (state_q == S_DONE) && mis_q;
        range_fault = (state_q == S_DONE) && rf_q;
    end

    // ------------------------------------------------------------------
    // Request latch and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= OP_LB;
            addr_q        <= 32'h0000_0000;
            data_q        <= 32'h0000_0000;
            merge_q       <= 32'h0000_0000;
            load_result_q <= 32'h0000_0000;
            mis_q         <= 1'b0;
            rf_q          <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        addr_q <= addr;
                        data_q <= store_data;
                        mis_q  <= req_mis;
                        rf_q   <= req_rf && !req_mis;
                    end
                end
                S_READ: begin
                    if (is_store(op_q)) begin
                        merge_q <= merge_word(mem_rdata, op_q, addr_q[1:0], data_q);
                    end else begin
                        load_result_q <= extend_load(mem_rdata, op_q, addr_q[1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_result = load_result_q;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    // SW skips the read, so its write data is the latched source word.
    assign mem_wdata   = (op_q == OP_SW) ? data_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam logic [31:0] LIMIT = 32'h0000_4000;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                           LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy, done, misaligned, range_fault, mem_read, mem_write;
    logic [31:0] load_result, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr),
        .store_data(store_data), .busy(busy), .done(done),
        .load_result(load_result), .misaligned(misaligned),
        .range_fault(range_fault), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, written on the clock edge.
    logic [31:0] mem [0:4095];
    logic        init_we;
    logic [11:0] init_idx;
    logic [31:0] init_val;

    assign mem_rdata = mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_write)    mem[mem_addr[13:2]] <= mem_wdata;
        else if (init_we) mem[init_idx] <= init_val;
    end

    // Strobe monitor, sampled mid-cycle.
    int          rd_cnt = 0, wr_cnt = 0;
    int          overlap_err = 0, busy_err = 0, done_err = 0;
    logic [31:0] last_raddr = 0, last_waddr = 0, last_wdata = 0;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (mem_read) begin
            rd_cnt++;
            last_raddr = mem_addr;
        end
        if (mem_write) begin
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_read && mem_write) overlap_err++;
        if (busy !== (mem_read | mem_write)) busy_err++;
        if (done && prev_done) done_err++;
        prev_done = done;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mem_init(input int idx, input logic [31:0] val);
        @(negedge clk);
        init_we  = 1'b1;
        init_idx = idx[11:0];
        init_val = val;
        @(negedge clk);
        init_we  = 1'b0;
    endtask

    // Issue one request and wait (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] res, output logic m, output logic r,
                          output int lat, output int nr, output int nw);
        int  rd0, wr0;
        bit  got;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        start = 1'b1; op = o; addr = a; store_data = d;
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                lat = c;
            end
        end
        check("done_timeout", 32'(got), 32'd1);
        res = load_result;
        m   = misaligned;
        r   = range_fault;
        nr  = rd_cnt - rd0;
        nw  = wr_cnt - wr0;
    endtask

    // Reference model: plain arithmetic on a byte-lane view of memory.
    logic [31:0] model_mem [0:63];
    logic [31:0] model_res = 32'h0;

    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] res, output logic m, output logic r,
                            output int lat, output int nr, output int nw);
        int unsigned width, sh;
        logic [31:0] mask, word, val;
        bit          st, sgn;
        width = (o == LB || o == LBU || o == SB) ? 1 :
                (o == LH || o == LHU || o == SH) ? 2 : 4;
        st    = (o >= SB);
        sgn   = (o == LB || o == LH);
        m     = (a % width) != 0;
        r     = !m && (a >= LIMIT);
        nr = 0; nw = 0;
        if (m || r) begin
            lat = 1;
        end else begin
            sh   = (4 - width - (a % 4)) * 8;
            mask = (width == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * width)) - 1);
            word = model_mem[a / 4];
            if (!st) begin
                val = (word >> sh) & mask;
                if (sgn && val[8 * width - 1]) val = val | ~mask;
                model_res = val;
                lat = 2; nr = 1;
            end else begin
                model_mem[a / 4] = (word & ~(mask << sh)) | ((d & mask) << sh);
                lat = (width == 4) ? 2 : 3;
                nr  = (width == 4) ? 0 : 1;
                nw  = 1;
            end
        end
        res = model_res;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] res;
        logic        mis;
        logic        rf;
        int          lat;
        int          nr;
        int          nw;
        logic [31:0] maddr;
        logic [31:0] wdata;
    } vec_t;

    function automatic vec_t mk(logic [2:0] o, logic [31:0] a, logic [31:0] d, logic [31:0] res,
                                logic mis, logic rf, int lat, int nr, int nw,
                                logic [31:0] maddr, logic [31:0] wdata);
        vec_t v;
        v.op = o; v.addr = a; v.data = d; v.res = res; v.mis = mis; v.rf = rf;
        v.lat = lat; v.nr = nr; v.nw = nw; v.maddr = maddr; v.wdata = wdata;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] res, eres;
        logic        m, r, em, er;
        int          lat, nr, nw, elat, enr, enw, wr0, got, mem_bad;
        logic [2:0]  ro;
        logic [31:0] ra, rd;

        rst_n = 1'b0; start = 1'b0; op = 3'd0; addr = 0; store_data = 0;
        init_we = 1'b0; init_idx = 0; init_val = 0;

        for (int i = 0; i < 64; i++) mem_init(i, 32'h0);
        mem_init(0, 32'h0030_5060);
        mem_init(1, 32'h40FF_FFFF);

        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_strobes", {30'b0, mem_read, mem_write}, 0);
        check("reset_flags", {30'b0, misaligned, range_fault}, 0);
        check("reset_load_result", load_result, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {28'b0, busy, done, mem_read, mem_write}, 0);

        // op, addr, data, result, mis, rf, latency, reads, writes, strobe addr, wdata
        vecs.push_back(mk(LB,  32'h0001, 0,            32'h0000_0030, 0, 0, 2, 1, 0, 32'h0, 0));
        vecs.push_back(mk(LB,  32'h0005, 0,            32'hFFFF_FFFF, 0, 0, 2, 1, 0, 32'h4, 0));
        vecs.push_back(mk(LBU, 32'h0005, 0,            32'h0000_00FF, 0, 0, 2, 1, 0, 32'h4, 0));
        vecs.push_back(mk(LH,  32'h0004, 0,            32'h0000_40FF, 0, 0, 2, 1, 0, 32'h4, 0));
        vecs.push_back(mk(LHU, 32'h0006, 0,            32'h0000_FFFF, 0, 0, 2, 1, 0, 32'h4, 0));
        vecs.push_back(mk(SB,  32'h0002, 32'h0000_00AB, 32'h0000_FFFF, 0, 0, 3, 1, 1, 32'h0, 32'h0030_AB60));
        vecs.push_back(mk(LW,  32'h0000, 0,            32'h0030_AB60, 0, 0, 2, 1, 0, 32'h0, 0));
        vecs.push_back(mk(SW,  32'h0008, 32'h1234_5678, 32'h0030_AB60, 0, 0, 2, 0, 1, 32'h8, 32'h1234_5678));
        vecs.push_back(mk(SH,  32'h0003, 32'h0000_BEEF, 32'h0030_AB60, 1, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(LW,  32'h4000, 0,            32'h0030_AB60, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(LW,  32'h4001, 0,            32'h0030_AB60, 1, 0, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(LH,  32'h4002, 0,            32'h0030_AB60, 0, 1, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(LW,  32'h0008, 0,            32'h1234_5678, 0, 0, 2, 1, 0, 32'h8, 0));
        vecs.push_back(mk(SH,  32'h0006, 32'hFFFF_1234, 32'h1234_5678, 0, 0, 3, 1, 1, 32'h4, 32'h40FF_1234));
        vecs.push_back(mk(LB,  32'h0007, 0,            32'h0000_0034, 0, 0, 2, 1, 0, 32'h4, 0));
        vecs.push_back(mk(LBU, 32'h0004, 0,            32'h0000_0040, 0, 0, 2, 1, 0, 32'h4, 0));
        vecs.push_back(mk(LHU, 32'h0000, 0,            32'h0000_0030, 0, 0, 2, 1, 0, 32'h0, 0));
        vecs.push_back(mk(LH,  32'h0002, 0,            32'hFFFF_AB60, 0, 0, 2, 1, 0, 32'h0, 0));

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].data, res, m, r, lat, nr, nw);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_misaligned", i), 32'(m), 32'(vecs[i].mis));
            check($sformatf("vec%0d_range_fault", i), 32'(r), 32'(vecs[i].rf));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_reads", i), nr, vecs[i].nr);
            check($sformatf("vec%0d_writes", i), nw, vecs[i].nw);
            if (vecs[i].nr > 0) check($sformatf("vec%0d_read_addr", i), last_raddr, vecs[i].maddr);
            if (vecs[i].nw > 0) begin
                check($sformatf("vec%0d_write_addr", i), last_waddr, vecs[i].maddr);
                check($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].wdata);
            end
        end
        check("table_word0", mem[0], 32'h0030_AB60);
        check("table_word1", mem[1], 32'h40FF_1234);
        check("table_word2", mem[2], 32'h1234_5678);

        // start held high through a whole SB, including the DONE->IDLE edge.
        @(negedge clk);
        wr0 = wr_cnt;
        start = 1'b1; op = SB; addr = 32'h000C; store_data = 32'h0000_0077;
        @(posedge clk);
        #1 op = SW; addr = 32'h0010; store_data = 32'hDEAD_BEEF;
        got = 0; lat = 0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            @(negedge clk);
            if (done) begin got = 1; lat = c; end
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_ignore_done", got, 1);
        check("busy_ignore_latency", lat, 3);
        check("busy_ignore_writes", wr_cnt - wr0, 1);
        check("busy_ignore_waddr", last_waddr, 32'h0000_000C);
        check("busy_ignore_word3", mem[3], 32'h7700_0000);
        check("busy_ignore_word4", mem[4], 32'h0000_0000);

        // Reset asserted while the SB read is in flight.
        @(negedge clk);
        wr0 = wr_cnt;
        start = 1'b1; op = SB; addr = 32'h0001; store_data = 32'h0000_0099;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("rst_mid_read_active", 32'(mem_read), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_read", 32'(mem_read), 0);
        check("rst_mid_ctrl", {26'b0, busy, done, misaligned, range_fault, mem_read, mem_write}, 0);
        check("rst_mid_load_result", load_result, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        check("rst_mid_mem_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_write", wr_cnt - wr0, 0);
        check("rst_mid_word0", mem[0], 32'h0030_AB60);

        // Randomized requests against the reference model.
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = $urandom;
            mem_init(i, model_mem[i]);
        end
        model_res = 32'h0;
        for (int t = 0; t < 300; t++) begin
            ro = 3'($urandom_range(0, 7));
            rd = $urandom;
            case ($urandom_range(0, 9))
                0:       ra = LIMIT + 32'($urandom_range(0, 255));
                1:       ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                default: ra = 32'($urandom_range(0, 255));
            endcase
            model_op(ro, ra, rd, eres, em, er, elat, enr, enw);
            run_op(ro, ra, rd, res, m, r, lat, nr, nw);
            check($sformatf("rand%0d_op%0d_a%0h_result", t, ro, ra), res, eres);
            check($sformatf("rand%0d_flags", t), {30'b0, m, r}, {30'b0, em, er});
            check($sformatf("rand%0d_latency", t), lat, elat);
            check($sformatf("rand%0d_strobes", t), {nr[15:0], nw[15:0]}, {enr[15:0], enw[15:0]});
        end
        mem_bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== model_mem[i]) mem_bad++;
        check("rand_memory_words_differing", mem_bad, 0);

        check("strobe_overlap", overlap_err, 0);
        check("busy_vs_strobes", busy_err, 0);
        check("done_single_pulse", done_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
